// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_st_t;

  localparam int DIV_N_DEFAULT = 8;

endpackage

// File: rtl/div_sub_step.sv
// One restoring shift-subtract step: trial-subtract divisor from {acc,msb}; purely combinational.
// No state, so no latency or backpressure of its own.
module div_sub_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] acc,
  input  logic         msb,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] next_acc,
  output logic         q_bit
);

  logic [N:0] cat;

  always_comb begin
    cat   = {acc, msb};
    q_bit = (cat >= {1'b0, divisor});
    // When the trial succeeds the difference is below divisor, so it fits N bits.
    next_acc = q_bit ? N'(cat - {1'b0, divisor}) : cat[N-1:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative N-bit divider: N+1 cycles start-to-done (1 on divide-by-zero); start ignored while busy.
// Optional div0 output when DIV_ZERO_FLAG_EN is defined.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
`ifdef DIV_ZERO_FLAG_EN
  output logic [N-1:0] remainder,
  output logic         div0
`else
  output logic [N-1:0] remainder
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  div_st_t       state_q, state_d;
  logic [N-1:0]  dvd_q, dvs_q, acc_q, qr_q;
  logic [CW-1:0] cnt_q;
  logic          load, zload, iter, fin;
  logic [N-1:0]  next_acc;
  logic          q_bit;

  div_sub_step #(.N(N)) u_step (
    .acc      (acc_q),
    .msb      (dvd_q[N-1]),
    .divisor  (dvs_q),
    .next_acc (next_acc),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    zload   = 1'b0;
    iter    = 1'b0;
    fin     = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            zload   = 1'b1;
            state_d = DONE;
          end else begin
            load    = 1'b1;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        iter = 1'b1;
        if (cnt_q == '0) begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      acc_q     <= '0;
      qr_q      <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (load) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
        acc_q <= '0;
        qr_q  <= '0;
        cnt_q <= CW'(N - 1);
      end else if (iter) begin
        dvd_q <= dvd_q << 1;
        acc_q <= next_acc;
        qr_q  <= (qr_q << 1) | N'(q_bit);
        if (!fin) cnt_q <= cnt_q - 1'b1;
      end
      if (zload) begin
        quotient  <= '0;
        remainder <= dividend;
      end else if (fin) begin
        quotient  <= (qr_q << 1) | N'(q_bit);
        remainder <= next_acc;
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)        div0 <= 1'b0;
    else if (zload) div0 <= 1'b1;
    else if (fin)   div0 <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed literal cases plus random traffic checked every cycle
// against a transaction-level model (a/b, a%b, fixed latency).
module tb_div_seq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done;
  logic [N-1:0] quotient, remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic         div0;
`endif

  int total = 0;
  int bad = 0;

  div_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
`ifdef DIV_ZERO_FLAG_EN
    .remainder (remainder),
    .div0      (div0)
`else
    .remainder (remainder)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: edge counter, accept window, pending result.
  int ec = 0;
  int m_free = 0, m_start = 0, m_fin = -1;
  bit m_active = 0;
  int p_q, p_r, p_d0;
  int m_q = 0, m_r = 0, m_d0 = 0;

  always @(posedge clk) begin
    ec++;
    if (rst) begin
      m_active = 0;
      m_free = ec + 1;
      m_q = 0; m_r = 0; m_d0 = 0;
    end else begin
      if (m_active && ec == m_fin) begin
        m_q = p_q; m_r = p_r; m_d0 = p_d0;
      end
      if (ec >= m_free && start) begin
        if (divisor == 0) begin
          p_q = 0; p_r = int'(dividend); p_d0 = 1;
          m_fin = ec;
        end else begin
          p_q = int'(dividend) / int'(divisor);
          p_r = int'(dividend) % int'(divisor);
          p_d0 = 0;
          m_fin = ec + N;
        end
        m_start = ec;
        m_free = m_fin + 2;
        m_active = 1;
        if (m_fin == ec) begin
          m_q = p_q; m_r = p_r; m_d0 = p_d0;
        end
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", int'(busy), int'(m_active && ec >= m_start && ec <= m_fin));
      check("done", int'(done), int'(m_active && ec == m_fin));
      check("quotient", int'(quotient), m_q);
      check("remainder", int'(remainder), m_r);
`ifdef DIV_ZERO_FLAG_EN
      check("div0", int'(div0), m_d0);
`endif
    end
  end

  // Issue one request and wait (bounded) for done; checks literal results and latency.
  task automatic run_div(input int a, input int b, input int eq, input int er,
                         input int ed0, input int elat);
    int lat, busyc;
    bit got;
    @(negedge clk);
    dividend = N'(a); divisor = N'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = N'($urandom); divisor = N'($urandom);
    lat = 0; busyc = 0; got = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (i > 1) @(negedge clk);
      if (busy) busyc++;
      if (done) begin got = 1; lat = i; end
    end
    check("run_done_seen", int'(got), 1);
    check("run_latency", lat, elat);
    check("run_busy_cycles", busyc, elat);
    check("run_quotient", int'(quotient), eq);
    check("run_remainder", int'(remainder), er);
`ifdef DIV_ZERO_FLAG_EN
    check("run_div0", int'(div0), ed0);
`endif
  endtask

  initial begin
    int dcnt, prev, nc;
    int dq[$];

    repeat (2) @(negedge clk);
    cmp_en = 1;
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);

    run_div(200, 7, 28, 4, 0, 9);
    run_div(255, 1, 255, 0, 0, 9);
    run_div(5, 9, 0, 5, 0, 9);
    run_div(8, 8, 1, 0, 0, 9);
    run_div(8'h2A, 0, 0, 8'h2A, 1, 1);
    run_div(10, 3, 3, 1, 0, 9);

    // Second start during the run must be ignored; operands scrambled mid-run.
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd10; start = 1'b1;
    dcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = (i == 4);
      if (i == 4) begin dividend = 8'd50; divisor = 8'd5; end
      else begin dividend = N'($urandom); divisor = N'($urandom_range(1, 255)); end
      if (done) dcnt++;
    end
    start = 1'b0;
    check("ignore_done_count", dcnt, 1);
    check("ignore_quotient", int'(quotient), 10);
    check("ignore_remainder", int'(remainder), 0);

    // Reset in the middle of 200/7.
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run_div(9, 2, 4, 1, 0, 9);

    // start held high: repeated acceptance with fixed spacing.
    @(negedge clk);
    dividend = 8'd17; divisor = 8'd4; start = 1'b1;
    prev = 0; nc = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      nc++;
      if (done) begin
        dq.push_back(nc);
        check("hold_consecutive_done", int'(prev), 0);
        check("hold_quotient", int'(quotient), 4);
        check("hold_remainder", int'(remainder), 1);
      end
      prev = int'(done);
    end
    start = 1'b0;
    check("hold_done_count", dq.size(), 4);
    for (int i = 1; i < dq.size(); i++) check("hold_spacing", dq[i] - dq[i-1], N + 2);
    repeat (12) @(negedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 149) == 0);
      start    = ($urandom_range(0, 3) == 0);
      dividend = N'($urandom);
      divisor  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);
    cmp_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
